// File: rtl/ni_pkt_framer.sv
// ni_pkt_framer: NI framing stage between the AXI slave buffers and the
// local router port. TX turns a raw beat stream into HEAD/BODY/TAIL flits with
// per-VC packet tracking and a registered output toward the NoC. RX forwards
// flits combinationally with the type stripped, checks per-VC framing, and
// keeps sticky error flags plus error and packet counters.
//
// Handshake rule on every valid/ready pair in this block: a transfer happens
// on a rising edge where valid and ready are both high. The source holds the
// payload steady while valid is high and ready is low. valid never depends
// combinationally on ready. ready may depend combinationally on valid.
module ni_pkt_framer #(
  parameter int NUM_VC      = 2,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_W    = 8,
  parameter int CNT_W       = 16,
  localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int FLIT_W     = FLIT_DATA_W + 2
) (
  input  logic                   clk,
  input  logic                   arst,
  // beat stream from the AXI write path
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [FLIT_DATA_W-1:0] tx_data,
  input  logic [VC_W-1:0]        tx_vc,
  input  logic [PKT_SZ_W-1:0]    tx_pkt_sz,
  // flits toward the router local input
  output logic                   noc_tx_valid,
  input  logic                   noc_tx_ready,
  output logic [FLIT_W-1:0]      noc_tx_fdata,
  output logic [VC_W-1:0]        noc_tx_vc,
  // flits from the router local output
  input  logic                   noc_rx_valid,
  output logic                   noc_rx_ready,
  input  logic [FLIT_W-1:0]      noc_rx_fdata,
  input  logic [VC_W-1:0]        noc_rx_vc,
  // payload toward the AXI RX buffer
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [FLIT_DATA_W-1:0] rx_data,
  output logic [VC_W-1:0]        rx_vc,
  output logic                   rx_first,
  output logic                   rx_last,
  output logic                   rx_err,
  // status
  input  logic                   err_clr,
  output logic [NUM_VC-1:0]      err_vc,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       tx_pkt_cnt,
  output logic [CNT_W-1:0]       rx_pkt_cnt
);

  // Flit type lives in the two top bits of every flit.
  typedef enum logic [1:0] {
    FT_HEAD = 2'b00,
    FT_BODY = 2'b01,
    FT_TAIL = 2'b10,
    FT_BAD  = 2'b11
  } flit_type_e;

  localparam int HEAD_PAY_W = FLIT_DATA_W - PKT_SZ_W;
  localparam logic [PKT_SZ_W-1:0] REM_ONE  = PKT_SZ_W'(1);
  localparam logic [PKT_SZ_W-1:0] REM_ZERO = '0;
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // TX framing
  // ---------------------------------------------------------------------------
  logic [NUM_VC-1:0]   tx_busy_q;
  logic [PKT_SZ_W-1:0] tx_rem_q [NUM_VC];

  logic                tx_acc;
  logic                tx_cur_busy;
  logic [PKT_SZ_W-1:0] tx_cur_rem;
  logic [FLIT_W-1:0]   tx_flit;
  logic                tx_done;
  logic                tx_nxt_busy;
  logic [PKT_SZ_W-1:0] tx_nxt_rem;

  // The output register can take a new flit when empty or draining this cycle.
  assign tx_ready    = !noc_tx_valid || noc_tx_ready;
  assign tx_acc      = tx_valid && tx_ready;
  assign tx_cur_busy = tx_busy_q[tx_vc];
  assign tx_cur_rem  = tx_rem_q[tx_vc];

  // Build the flit for the current beat from the target VC's framing state.
  always_comb begin
    tx_flit     = '0;
    tx_done     = 1'b0;
    tx_nxt_busy = tx_cur_busy;
    tx_nxt_rem  = tx_cur_rem;
    if (!tx_cur_busy) begin
      // First beat of a packet: size field plus the low payload bits.
      tx_flit     = {FT_HEAD, tx_pkt_sz, tx_data[HEAD_PAY_W-1:0]};
      tx_nxt_rem  = tx_pkt_sz;
      tx_nxt_busy = (tx_pkt_sz != REM_ZERO);
      tx_done     = (tx_pkt_sz == REM_ZERO);
    end else if (tx_cur_rem <= REM_ONE) begin
      // Last flit of the packet.
      tx_flit     = {FT_TAIL, tx_data};
      tx_nxt_busy = 1'b0;
      tx_done     = 1'b1;
    end else begin
      tx_flit     = {FT_BODY, tx_data};
      tx_nxt_rem  = tx_cur_rem - REM_ONE;
    end
  end

  // Per-VC TX framing state; only the accepted beat's VC moves.
  always_ff @(posedge clk) begin
    if (arst) begin
      tx_busy_q <= '0;
      for (int i = 0; i < NUM_VC; i++) tx_rem_q[i] <= '0;
    end else if (tx_acc) begin
      tx_busy_q[tx_vc] <= tx_nxt_busy;
      tx_rem_q[tx_vc]  <= tx_nxt_rem;
    end
  end

  // Output register toward the router: load on accept, drop once drained.
  always_ff @(posedge clk) begin
    if (arst) begin
      noc_tx_valid <= 1'b0;
      noc_tx_fdata <= '0;
      noc_tx_vc    <= '0;
    end else if (tx_acc) begin
      noc_tx_valid <= 1'b1;
      noc_tx_fdata <= tx_flit;
      noc_tx_vc    <= tx_vc;
    end else if (noc_tx_ready) begin
      noc_tx_valid <= 1'b0;
    end
  end

  // Completed TX packets, wrapping.
  always_ff @(posedge clk) begin
    if (arst) begin
      tx_pkt_cnt <= '0;
    end else if (tx_acc && tx_done) begin
      tx_pkt_cnt <= tx_pkt_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // RX pass-through and framing checker
  // ---------------------------------------------------------------------------
  logic [NUM_VC-1:0]   rx_busy_q;
  logic [PKT_SZ_W-1:0] rx_rem_q [NUM_VC];

  flit_type_e          rx_type;
  logic [PKT_SZ_W-1:0] rx_size;
  logic                rx_acc;
  logic                rx_cur_busy;
  logic [PKT_SZ_W-1:0] rx_cur_rem;
  logic                rx_bad;
  logic                rx_done;
  logic                rx_nxt_busy;
  logic [PKT_SZ_W-1:0] rx_nxt_rem;
  logic [NUM_VC-1:0]   err_vc_nxt;

  assign rx_type      = flit_type_e'(noc_rx_fdata[FLIT_W-1 -: 2]);
  assign rx_size      = noc_rx_fdata[FLIT_DATA_W-1 -: PKT_SZ_W];
  assign rx_acc       = noc_rx_valid && rx_ready;
  assign rx_cur_busy  = rx_busy_q[noc_rx_vc];
  assign rx_cur_rem   = rx_rem_q[noc_rx_vc];

  assign rx_valid     = noc_rx_valid;
  assign noc_rx_ready = rx_ready;
  assign rx_data      = noc_rx_fdata[FLIT_DATA_W-1:0];
  assign rx_vc        = noc_rx_vc;
  assign rx_first     = (rx_type == FT_HEAD);
  assign rx_last      = ((rx_type == FT_HEAD) && (rx_size == REM_ZERO)) ||
                        (rx_type == FT_TAIL);
  // Errors are flagged but the flit is forwarded regardless.
  assign rx_err       = noc_rx_valid && rx_bad;

  // Classify the incoming flit against its VC's expected framing.
  always_comb begin
    rx_bad      = 1'b0;
    rx_done     = 1'b0;
    rx_nxt_busy = rx_cur_busy;
    rx_nxt_rem  = rx_cur_rem;
    case (rx_type)
      FT_HEAD: begin
        // A head always restarts the packet; it is only wrong mid-packet.
        rx_bad      = rx_cur_busy;
        rx_nxt_rem  = rx_size;
        rx_nxt_busy = (rx_size != REM_ZERO);
        rx_done     = (rx_size == REM_ZERO);
      end
      FT_BODY: begin
        if (!rx_cur_busy) begin
          rx_bad = 1'b1;
        end else if (rx_cur_rem > REM_ONE) begin
          rx_nxt_rem = rx_cur_rem - REM_ONE;
        end else begin
          // Body where the tail was due: keep waiting for the tail.
          rx_bad = 1'b1;
        end
      end
      FT_TAIL: begin
        if (!rx_cur_busy) begin
          rx_bad = 1'b1;
        end else begin
          rx_nxt_busy = 1'b0;
          rx_nxt_rem  = REM_ZERO;
          if (rx_cur_rem == REM_ONE) rx_done = 1'b1;
          else                       rx_bad  = 1'b1;
        end
      end
      default: begin
        // Reserved type: flagged, state untouched.
        rx_bad = 1'b1;
      end
    endcase
  end

  // Per-VC RX checker state; only the accepted flit's VC moves.
  always_ff @(posedge clk) begin
    if (arst) begin
      rx_busy_q <= '0;
      for (int i = 0; i < NUM_VC; i++) rx_rem_q[i] <= '0;
    end else if (rx_acc) begin
      rx_busy_q[noc_rx_vc] <= rx_nxt_busy;
      rx_rem_q[noc_rx_vc]  <= rx_nxt_rem;
    end
  end

  // Sticky error flags: clear first, then a same-cycle error wins its bit.
  always_comb begin
    err_vc_nxt = err_clr ? '0 : err_vc;
    if (rx_acc && rx_bad) err_vc_nxt[noc_rx_vc] = 1'b1;
  end

  // Error flags and saturating error counter.
  always_ff @(posedge clk) begin
    if (arst) begin
      err_vc  <= '0;
      err_cnt <= '0;
    end else begin
      err_vc <= err_vc_nxt;
      if (rx_acc && rx_bad && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

  // Legally completed RX packets, wrapping.
  always_ff @(posedge clk) begin
    if (arst) begin
      rx_pkt_cnt <= '0;
    end else if (rx_acc && rx_done) begin
      rx_pkt_cnt <= rx_pkt_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ni_pkt_framer.sv
// Directed bench for ni_pkt_framer: TX framing, interleaving, backpressure,
// RX checking/errors and reset behaviour, with hand-computed expectations.
module tb_ni_pkt_framer;

  localparam int NUM_VC = 2;
  localparam int FDW    = 32;
  localparam int SZW    = 8;
  localparam int CNTW   = 16;
  localparam int VCW    = 1;
  localparam int FW     = FDW + 2;

  logic            clk = 1'b0;
  logic            arst;
  logic            tx_valid, tx_ready;
  logic [FDW-1:0]  tx_data;
  logic [VCW-1:0]  tx_vc;
  logic [SZW-1:0]  tx_pkt_sz;
  logic            noc_tx_valid, noc_tx_ready;
  logic [FW-1:0]   noc_tx_fdata;
  logic [VCW-1:0]  noc_tx_vc;
  logic            noc_rx_valid, noc_rx_ready;
  logic [FW-1:0]   noc_rx_fdata;
  logic [VCW-1:0]  noc_rx_vc;
  logic            rx_valid, rx_ready;
  logic [FDW-1:0]  rx_data;
  logic [VCW-1:0]  rx_vc;
  logic            rx_first, rx_last, rx_err;
  logic            err_clr;
  logic [NUM_VC-1:0] err_vc;
  logic [CNTW-1:0] err_cnt, tx_pkt_cnt, rx_pkt_cnt;

  int n_vec = 0;
  int n_err = 0;

  ni_pkt_framer #(
    .NUM_VC(NUM_VC), .FLIT_DATA_W(FDW), .PKT_SZ_W(SZW), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .arst(arst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_vc(tx_vc), .tx_pkt_sz(tx_pkt_sz),
    .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_tx_fdata(noc_tx_fdata), .noc_tx_vc(noc_tx_vc),
    .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
    .noc_rx_fdata(noc_rx_fdata), .noc_rx_vc(noc_rx_vc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_vc(rx_vc), .rx_first(rx_first), .rx_last(rx_last), .rx_err(rx_err),
    .err_clr(err_clr), .err_vc(err_vc), .err_cnt(err_cnt),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt)
  );

  // Clock and run-time guard.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

  // Driver tasks. Inputs change 1 time unit after the rising edge, and
  // outputs are sampled at that same point, clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [VCW-1:0] vc, input logic [SZW-1:0] sz,
                      input logic [FDW-1:0] d);
    tx_valid  = 1'b1;
    tx_vc     = vc;
    tx_pkt_sz = sz;
    tx_data   = d;
    step();
  endtask

  task automatic tx_idle();
    tx_valid = 1'b0;
    step();
  endtask

  task automatic rx_drive(input logic [VCW-1:0] vc, input logic [FW-1:0] f);
    noc_rx_valid = 1'b1;
    noc_rx_vc    = vc;
    noc_rx_fdata = f;
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    tx_valid = 1'b0; tx_data = '0; tx_vc = '0; tx_pkt_sz = '0;
    noc_tx_ready = 1'b1;
    noc_rx_valid = 1'b0; noc_rx_fdata = '0; noc_rx_vc = '0;
    rx_ready = 1'b1; err_clr = 1'b0;
    step(); step();
    n_vec++; if (noc_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_noc_tx_valid: got %b want 0", noc_tx_valid); end
    n_vec++; if (noc_tx_fdata !== '0) begin n_err++; $display("FAIL rst_noc_tx_fdata: got %h want 0", noc_tx_fdata); end
    n_vec++; if (noc_tx_vc !== '0) begin n_err++; $display("FAIL rst_noc_tx_vc: got %h want 0", noc_tx_vc); end
    n_vec++; if (err_vc !== 2'b00) begin n_err++; $display("FAIL rst_err_vc: got %b want 00", err_vc); end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    n_vec++; if (tx_pkt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_tx_pkt_cnt: got %0d want 0", tx_pkt_cnt); end
    n_vec++; if (rx_pkt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_rx_pkt_cnt: got %0d want 0", rx_pkt_cnt); end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    arst = 1'b0;
    step();
  endtask

  task automatic test_tx_packet();
    logic [FW-1:0] exp [4];
    exp[0] = {2'b00, 8'h03, 24'h0000A0};
    exp[1] = {2'b01, 32'h000000A1};
    exp[2] = {2'b01, 32'h000000A2};
    exp[3] = {2'b10, 32'h000000A3};
    for (int i = 0; i < 4; i++) begin
      // size input after the head is junk and must be ignored
      beat(1'b1, (i == 0) ? 8'h03 : 8'h55, 32'hA0 + i);
      n_vec++; if (noc_tx_valid !== 1'b1) begin n_err++; $display("FAIL pkt_valid[%0d]: got %b want 1", i, noc_tx_valid); end
      n_vec++; if (noc_tx_fdata !== exp[i]) begin n_err++; $display("FAIL pkt_flit[%0d]: got %h want %h", i, noc_tx_fdata, exp[i]); end
      n_vec++; if (noc_tx_vc !== 1'b1) begin n_err++; $display("FAIL pkt_vc[%0d]: got %h want 1", i, noc_tx_vc); end
    end
    tx_idle();
    n_vec++; if (noc_tx_valid !== 1'b0) begin n_err++; $display("FAIL pkt_drain: got %b want 0", noc_tx_valid); end
    n_vec++; if (tx_pkt_cnt !== 16'd1) begin n_err++; $display("FAIL pkt_cnt: got %0d want 1", tx_pkt_cnt); end
  endtask

  task automatic test_interleave();
    logic [VCW-1:0] vcs [6];
    logic [SZW-1:0] szs [6];
    logic [FDW-1:0] dat [6];
    logic [FW-1:0]  exp [6];
    vcs[0] = 1'b0; szs[0] = 8'd2; dat[0] = 32'hB0; exp[0] = {2'b00, 8'h02, 24'h0000B0};
    vcs[1] = 1'b1; szs[1] = 8'd1; dat[1] = 32'hC0; exp[1] = {2'b00, 8'h01, 24'h0000C0};
    vcs[2] = 1'b0; szs[2] = 8'd9; dat[2] = 32'hB1; exp[2] = {2'b01, 32'h000000B1};
    vcs[3] = 1'b1; szs[3] = 8'd9; dat[3] = 32'hC1; exp[3] = {2'b10, 32'h000000C1};
    vcs[4] = 1'b0; szs[4] = 8'd9; dat[4] = 32'hB2; exp[4] = {2'b10, 32'h000000B2};
    // zero-size head is a complete single-flit packet
    vcs[5] = 1'b0; szs[5] = 8'd0; dat[5] = 32'h123456D0; exp[5] = {2'b00, 8'h00, 24'h3456D0};
    for (int i = 0; i < 6; i++) begin
      beat(vcs[i], szs[i], dat[i]);
      n_vec++; if (noc_tx_fdata !== exp[i]) begin n_err++; $display("FAIL ilv_flit[%0d]: got %h want %h", i, noc_tx_fdata, exp[i]); end
      n_vec++; if (noc_tx_vc !== vcs[i]) begin n_err++; $display("FAIL ilv_vc[%0d]: got %h want %h", i, noc_tx_vc, vcs[i]); end
      if (i == 4) begin
        n_vec++; if (tx_pkt_cnt !== 16'd3) begin n_err++; $display("FAIL ilv_cnt: got %0d want 3", tx_pkt_cnt); end
      end
    end
    tx_idle();
    n_vec++; if (tx_pkt_cnt !== 16'd4) begin n_err++; $display("FAIL single_head_cnt: got %0d want 4", tx_pkt_cnt); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] head_f, tail_f;
    head_f = {2'b00, 8'h01, 24'h0000E0};
    tail_f = {2'b10, 32'h000000E1};
    beat(1'b0, 8'd1, 32'hE0);
    noc_tx_ready = 1'b0;
    tx_valid = 1'b1; tx_vc = 1'b0; tx_pkt_sz = 8'd7; tx_data = 32'hE1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL bp_tx_ready[%0d]: got %b want 0", i, tx_ready); end
      n_vec++; if (noc_tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, noc_tx_valid); end
      n_vec++; if (noc_tx_fdata !== head_f) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, noc_tx_fdata, head_f); end
      step();
    end
    noc_tx_ready = 1'b1;
    #1;
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", tx_ready); end
    step();
    n_vec++; if (noc_tx_fdata !== tail_f) begin n_err++; $display("FAIL bp_tail: got %h want %h", noc_tx_fdata, tail_f); end
    tx_idle();
    n_vec++; if (noc_tx_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", noc_tx_valid); end
    n_vec++; if (tx_pkt_cnt !== 16'd5) begin n_err++; $display("FAIL bp_cnt: got %0d want 5", tx_pkt_cnt); end
  endtask

  task automatic test_rx_legal();
    rx_drive(1'b0, {2'b00, 8'h02, 24'h000011});
    n_vec++; if (rx_data !== 32'h02000011) begin n_err++; $display("FAIL rx_head_data: got %h want 02000011", rx_data); end
    n_vec++; if ({rx_valid, noc_rx_ready, rx_vc} !== 3'b110) begin n_err++; $display("FAIL rx_head_hs: got %b want 110", {rx_valid, noc_rx_ready, rx_vc}); end
    n_vec++; if ({rx_first, rx_last, rx_err} !== 3'b100) begin n_err++; $display("FAIL rx_head_flags: got %b want 100", {rx_first, rx_last, rx_err}); end
    step();
    rx_drive(1'b0, {2'b01, 32'h00000022});
    n_vec++; if ({rx_first, rx_last, rx_err} !== 3'b000) begin n_err++; $display("FAIL rx_body_flags: got %b want 000", {rx_first, rx_last, rx_err}); end
    step();
    rx_drive(1'b0, {2'b10, 32'h00000033});
    n_vec++; if ({rx_first, rx_last, rx_err} !== 3'b010) begin n_err++; $display("FAIL rx_tail_flags: got %b want 010", {rx_first, rx_last, rx_err}); end
    n_vec++; if (rx_data !== 32'h00000033) begin n_err++; $display("FAIL rx_tail_data: got %h want 00000033", rx_data); end
    step();
    noc_rx_valid = 1'b0;
    n_vec++; if (rx_pkt_cnt !== 16'd1) begin n_err++; $display("FAIL rx_pkt_cnt: got %0d want 1", rx_pkt_cnt); end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL rx_legal_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_rx_errors();
    rx_drive(1'b1, {2'b01, 32'h00000044});
    n_vec++; if (rx_err !== 1'b1) begin n_err++; $display("FAIL err_body_idle: got %b want 1", rx_err); end
    step();
    n_vec++; if (err_vc !== 2'b10) begin n_err++; $display("FAIL err_vc_1: got %b want 10", err_vc); end
    rx_drive(1'b1, {2'b00, 8'h03, 24'h000055});
    n_vec++; if (rx_err !== 1'b0) begin n_err++; $display("FAIL err_head_ok: got %b want 0", rx_err); end
    step();
    rx_drive(1'b1, {2'b00, 8'h03, 24'h000066});
    n_vec++; if (rx_err !== 1'b1) begin n_err++; $display("FAIL err_head_busy: got %b want 1", rx_err); end
    step();
    n_vec++; if (err_cnt !== 16'd2) begin n_err++; $display("FAIL err_cnt_2: got %0d want 2", err_cnt); end
    n_vec++; if (err_vc !== 2'b10) begin n_err++; $display("FAIL err_vc_2: got %b want 10", err_vc); end
    // clear collides with an early tail: the new error keeps its bit
    err_clr = 1'b1;
    rx_drive(1'b1, {2'b10, 32'h00000077});
    n_vec++; if (rx_err !== 1'b1) begin n_err++; $display("FAIL err_tail_early: got %b want 1", rx_err); end
    step();
    err_clr = 1'b0;
    n_vec++; if (err_vc !== 2'b10) begin n_err++; $display("FAIL err_vc_clr_collide: got %b want 10", err_vc); end
    n_vec++; if (err_cnt !== 16'd3) begin n_err++; $display("FAIL err_cnt_3: got %0d want 3", err_cnt); end
    n_vec++; if (rx_pkt_cnt !== 16'd1) begin n_err++; $display("FAIL err_no_pkt: got %0d want 1", rx_pkt_cnt); end
    // reserved type on idle VC0 but not accepted: flagged, not counted
    rx_ready = 1'b0;
    rx_drive(1'b0, {2'b11, 32'h00000088});
    n_vec++; if ({rx_err, noc_rx_ready} !== 2'b10) begin n_err++; $display("FAIL err_bad_type: got %b want 10", {rx_err, noc_rx_ready}); end
    step();
    n_vec++; if (err_cnt !== 16'd3) begin n_err++; $display("FAIL err_not_accepted: got %0d want 3", err_cnt); end
    noc_rx_valid = 1'b0;
    rx_ready = 1'b1;
    #1;
    n_vec++; if (rx_err !== 1'b0) begin n_err++; $display("FAIL err_gated_valid: got %b want 0", rx_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_vec++; if (err_vc !== 2'b00) begin n_err++; $display("FAIL err_vc_clear: got %b want 00", err_vc); end
  endtask

  task automatic test_reset_mid_packet();
    beat(1'b0, 8'd4, 32'hF0);
    n_vec++; if (noc_tx_fdata !== {2'b00, 8'h04, 24'h0000F0}) begin n_err++; $display("FAIL mid_head: got %h", noc_tx_fdata); end
    tx_valid = 1'b0;
    arst = 1'b1;
    step();
    arst = 1'b0;
    n_vec++; if ({noc_tx_valid, noc_tx_fdata} !== '0) begin n_err++; $display("FAIL mid_rst_out: got %h want 0", {noc_tx_valid, noc_tx_fdata}); end
    n_vec++; if ({tx_pkt_cnt, rx_pkt_cnt, err_cnt} !== '0) begin n_err++; $display("FAIL mid_rst_cnts: got %h want 0", {tx_pkt_cnt, rx_pkt_cnt, err_cnt}); end
    beat(1'b0, 8'd1, 32'hF1);
    n_vec++; if (noc_tx_fdata !== {2'b00, 8'h01, 24'h0000F1}) begin n_err++; $display("FAIL mid_rehead: got %h want %h", noc_tx_fdata, {2'b00, 8'h01, 24'h0000F1}); end
    tx_idle();
  endtask

  initial begin
    test_reset();
    test_tx_packet();
    test_interleave();
    test_backpressure();
    test_rx_legal();
    test_rx_errors();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
